// File: rtl/i2c_slave_sync.sv
// I2C target with an 8x8 byte register file, oversampled from the system clock.
// SCL/SDA are synchronized and edge-detected; SDA is only ever pulled low or released.
module i2c_slave_sync #(
    parameter logic [6:0]  SLAVE_ADDR  = 7'd25,
    parameter int unsigned MIN_SCL_LOW = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            SCL,
    inout  wire             SDA,
    output logic            req,
    output logic            read,
    output logic [2:0]      mem_pos,
    output logic [7:0][7:0] memory,
    output logic            busy
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned POS_W  = 3;

    // Sync (2) + edge detect (1) + output register (1) must fit inside one SCL phase.
    if (MIN_SCL_LOW < 4) begin : g_min_scl_check
        $error("MIN_SCL_LOW below synchronizer latency");
    end

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        ADDR_ACK  = 3'd2,
        WR_DATA   = 3'd3,
        WR_ACK    = 3'd4,
        RD_DATA   = 3'd5,
        RD_ACK    = 3'd6,
        WAIT_STOP = 3'd7
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          scl_sync, sda_sync;
    logic                scl_d, sda_d;
    logic                sda_oe, sda_oe_d;
    logic                req_d, read_d, busy_d, ack_seen, ack_seen_d, wr_pend, wr_pend_d;
    logic [BYTE_W-1:0]   shift_q, shift_d, byte_in, load_byte;
    logic [CNT_W-1:0]    bit_cnt, bit_cnt_d;
    logic [POS_W-1:0]    mem_pos_d;
    logic                scl_s, sda_s, scl_rise, scl_fall, start_c, stop_c, addr_hit_c;

    assign SDA = sda_oe ? 1'b0 : 1'bz;

    // Input synchronizers plus one delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], SCL};
            sda_sync <= {sda_sync[0], SDA};
            scl_d    <= scl_sync[1];
            sda_d    <= sda_sync[1];
        end
    end

    assign scl_s      = scl_sync[1];
    assign sda_s      = sda_sync[1];
    assign scl_rise   = scl_s & ~scl_d;
    assign scl_fall   = ~scl_s & scl_d;
    // SDA edges while SCL is high are bus conditions, even if SCL moved in the same sample.
    assign start_c    = scl_s & sda_d & ~sda_s;
    assign stop_c     = scl_s & ~sda_d & sda_s;
    assign byte_in    = {shift_q[BYTE_W-2:0], sda_s};
    assign addr_hit_c = (byte_in[BYTE_W-1:1] == SLAVE_ADDR);
    assign load_byte  = memory[mem_pos];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (stop_c) begin
            state_d = IDLE;
        end else if (start_c) begin
            state_d = ADDR;
        end else begin
            case (state_q)
                ADDR:     if (scl_rise && bit_cnt == CNT_W'(7))
                              state_d = addr_hit_c ? ADDR_ACK : WAIT_STOP;
                ADDR_ACK: if (scl_fall && sda_oe) state_d = read ? RD_DATA : WR_DATA;
                WR_DATA:  if (scl_rise && bit_cnt == CNT_W'(7)) state_d = WR_ACK;
                WR_ACK:   if (scl_fall && sda_oe) state_d = WR_DATA;
                RD_DATA:  if (scl_fall && bit_cnt == CNT_W'(7)) state_d = RD_ACK;
                RD_ACK: begin
                    if (scl_rise && sda_s)          state_d = WAIT_STOP;
                    else if (scl_fall && ack_seen)  state_d = RD_DATA;
                end
                default: ;
            endcase
        end
    end

    // Datapath next values; the ACK states use sda_oe itself to tell the two SCL falls apart.
    always_comb begin
        sda_oe_d   = sda_oe;
        req_d      = req;
        read_d     = read;
        busy_d     = busy;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt;
        ack_seen_d = ack_seen;
        wr_pend_d  = 1'b0;
        mem_pos_d  = mem_pos;
        if (wr_pend) mem_pos_d = POS_W'(mem_pos + POS_W'(1));
        if (stop_c || start_c) begin
            sda_oe_d   = 1'b0;
            req_d      = 1'b0;
            read_d     = 1'b0;
            busy_d     = start_c;
            shift_d    = '0;
            bit_cnt_d  = '0;
            ack_seen_d = 1'b0;
        end else begin
            case (state_q)
                ADDR: if (scl_rise) begin
                    shift_d   = byte_in;
                    bit_cnt_d = CNT_W'(bit_cnt + CNT_W'(1));
                    if (bit_cnt == CNT_W'(7) && addr_hit_c) begin
                        req_d  = 1'b1;
                        read_d = ~byte_in[0];
                    end
                end
                ADDR_ACK, WR_ACK: if (scl_fall) begin
                    if (!sda_oe) begin
                        sda_oe_d = 1'b1;
                    end else if (state_q == ADDR_ACK && read) begin
                        shift_d  = load_byte;
                        sda_oe_d = ~load_byte[BYTE_W-1];
                    end else begin
                        sda_oe_d = 1'b0;
                    end
                end
                WR_DATA: if (scl_rise) begin
                    shift_d   = byte_in;
                    bit_cnt_d = CNT_W'(bit_cnt + CNT_W'(1));
                    wr_pend_d = (bit_cnt == CNT_W'(7));
                end
                RD_DATA: if (scl_fall) begin
                    bit_cnt_d = CNT_W'(bit_cnt + CNT_W'(1));
                    if (bit_cnt == CNT_W'(7)) begin
                        sda_oe_d  = 1'b0;
                        mem_pos_d = POS_W'(mem_pos + POS_W'(1));
                    end else begin
                        shift_d  = {shift_q[BYTE_W-2:0], 1'b0};
                        sda_oe_d = ~shift_q[BYTE_W-2];
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        ack_seen_d = ~sda_s;
                    end else if (scl_fall && ack_seen) begin
                        ack_seen_d = 1'b0;
                        shift_d    = load_byte;
                        sda_oe_d   = ~load_byte[BYTE_W-1];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sda_oe   <= 1'b0;
            req      <= 1'b0;
            read     <= 1'b0;
            busy     <= 1'b0;
            shift_q  <= '0;
            bit_cnt  <= '0;
            ack_seen <= 1'b0;
            wr_pend  <= 1'b0;
            mem_pos  <= '0;
            memory   <= '0;
        end else begin
            sda_oe   <= sda_oe_d;
            req      <= req_d;
            read     <= read_d;
            busy     <= busy_d;
            shift_q  <= shift_d;
            bit_cnt  <= bit_cnt_d;
            ack_seen <= ack_seen_d;
            wr_pend  <= wr_pend_d;
            mem_pos  <= mem_pos_d;
            if (wr_pend) memory[mem_pos] <= shift_q;
        end
    end

endmodule

// File: tb/tb_i2c_slave_sync.sv
// Bit-banged I2C master driving i2c_slave_sync, checked against a byte-level register-file model.
module tb_i2c_slave_sync;

    localparam int unsigned H = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            scl_r;
    logic            m_low;
    wire             SDA;
    logic            req, read, busy;
    logic [2:0]      mem_pos;
    logic [7:0][7:0] memory;

    int              total = 0;
    int              bad = 0;
    logic [7:0]      mdl_mem [8];
    int              mdl_pos;

    assign SDA = m_low ? 1'b0 : 1'bz;
    pullup (SDA);

    always #5 clk = ~clk;

    i2c_slave_sync #(.SLAVE_ADDR(7'd25), .MIN_SCL_LOW(4)) dut (
        .clk(clk), .rst_n(rst_n), .SCL(scl_r), .SDA(SDA), .req(req), .read(read),
        .mem_pos(mem_pos), .memory(memory), .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic hp();
        repeat (H) @(negedge clk);
    endtask

    function automatic logic [63:0] mdl_packed();
        logic [7:0][7:0] p;
        for (int i = 0; i < 8; i++) p[i] = mdl_mem[i];
        return p;
    endfunction

    task automatic mdl_clear();
        for (int i = 0; i < 8; i++) mdl_mem[i] = 8'h00;
        mdl_pos = 0;
    endtask

    task automatic clock_bit(input logic b, output logic s);
        m_low = ~b;
        hp();
        scl_r = 1'b1;
        hp();
        s = (SDA !== 1'b0);
        scl_r = 1'b0;
        hp();
    endtask

    task automatic i2c_start();
        m_low = 1'b0;
        hp();
        scl_r = 1'b1;
        hp();
        m_low = 1'b1;
        hp();
        scl_r = 1'b0;
        hp();
    endtask

    task automatic i2c_stop();
        m_low = 1'b1;
        hp();
        scl_r = 1'b1;
        hp();
        m_low = 1'b0;
        hp();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
        clock_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d, output logic rel);
        logic s;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            clock_bit(1'b1, s);
            d = {d[6:0], s};
        end
        clock_bit(~mack, s);
        rel = s;
    endtask

    // Full write transaction; data is either first + step*k or random.
    task automatic write_txn(input int n, input int first, input int step, input logic rnd);
        logic       ack;
        logic [7:0] b;
        i2c_start();
        chk("wr_busy_after_start", busy, 1);
        chk("wr_req_before_addr", req, 0);
        write_byte(8'h33, ack);
        chk("wr_addr_ack", ack, 1);
        chk("wr_req_addressed", req, 1);
        chk("wr_read_flag", read, 0);
        for (int k = 0; k < n; k++) begin
            b = rnd ? 8'($urandom) : 8'(first + step * k);
            write_byte(b, ack);
            chk("wr_data_ack", ack, 1);
            mdl_mem[mdl_pos] = b;
            mdl_pos = (mdl_pos + 1) % 8;
        end
        i2c_stop();
        chk("wr_req_after_stop", req, 0);
        chk("wr_busy_after_stop", busy, 0);
        chk("wr_memory", memory, mdl_packed());
        chk("wr_mem_pos", mem_pos, 64'(mdl_pos));
    endtask

    // Full read transaction; master ACKs every byte except the last.
    task automatic read_txn(input int n);
        logic       ack, rel;
        logic [7:0] d;
        i2c_start();
        write_byte(8'h32, ack);
        chk("rd_addr_ack", ack, 1);
        chk("rd_read_flag", read, 1);
        chk("rd_req", req, 1);
        rel = 1'b0;
        for (int k = 0; k < n; k++) begin
            read_byte(k != n - 1, d, rel);
            chk("rd_data", d, 64'(mdl_mem[mdl_pos]));
            mdl_pos = (mdl_pos + 1) % 8;
        end
        chk("rd_released_after_nack", rel, 1);
        i2c_stop();
        chk("rd_read_after_stop", read, 0);
        chk("rd_mem_pos", mem_pos, 64'(mdl_pos));
    endtask

    initial begin
        logic       ack, rel, s;
        logic [7:0] d;

        rst_n = 1'b0;
        scl_r = 1'b1;
        m_low = 1'b0;
        mdl_clear();
        repeat (5) @(negedge clk);
        chk("rst_req", req, 0);
        chk("rst_read", read, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_pos", mem_pos, 0);
        chk("rst_memory", memory, 0);
        chk("rst_sda_low", SDA === 1'b0, 0);
        rst_n = 1'b1;
        hp();

        // Basic write A1 B2 C3 then read three bytes from positions 3..5.
        write_txn(3, 'hA1, 'h11, 1'b0);
        chk("wr_abc_memory_lo", memory[2:0], 64'hC3B2A1);
        read_txn(3);
        chk("rd_pos_after_3", mem_pos, 6);

        // Address 26: NACK on both ninth clocks, nothing stored.
        i2c_start();
        write_byte(8'h35, ack);
        chk("mis_addr_nack", ack, 0);
        chk("mis_req", req, 0);
        write_byte(8'($urandom), ack);
        chk("mis_data_nack", ack, 0);
        chk("mis_busy", busy, 1);
        i2c_stop();
        chk("mis_busy_after_stop", busy, 0);
        chk("mis_memory", memory, mdl_packed());
        chk("mis_mem_pos", mem_pos, 64'(mdl_pos));

        // Walk the pointer to 0 through the wrap, then write 01..0A.
        write_txn(2, 0, 0, 1'b1);
        chk("wrap_pos_zero", mem_pos, 0);
        write_txn(10, 1, 1, 1'b0);
        chk("wrap_memory", memory, 64'h0807060504030A09);
        chk("wrap_mem_pos", mem_pos, 2);

        for (int r = 0; r < 4; r++) begin
            write_txn(int'($urandom_range(1, 5)), 0, 0, 1'b1);
            read_txn(int'($urandom_range(1, 4)));
        end

        // Byte cut short by STOP is dropped.
        i2c_start();
        write_byte(8'h33, ack);
        d = 8'($urandom);
        write_byte(d, ack);
        mdl_mem[mdl_pos] = d;
        mdl_pos = (mdl_pos + 1) % 8;
        for (int i = 0; i < 3; i++) clock_bit(1'($urandom), s);
        i2c_stop();
        chk("partial_memory", memory, mdl_packed());
        chk("partial_mem_pos", mem_pos, 64'(mdl_pos));

        // Two writes, partial third byte, repeated START into a one-byte read.
        i2c_start();
        write_byte(8'h33, ack);
        for (int k = 0; k < 2; k++) begin
            d = 8'($urandom);
            write_byte(d, ack);
            chk("rs_data_ack", ack, 1);
            mdl_mem[mdl_pos] = d;
            mdl_pos = (mdl_pos + 1) % 8;
        end
        for (int i = 0; i < 3; i++) clock_bit(1'($urandom), s);
        chk("rs_busy_before_restart", busy, 1);
        i2c_start();
        write_byte(8'h32, ack);
        chk("rs_read_addr_ack", ack, 1);
        chk("rs_read_flag", read, 1);
        read_byte(1'b0, d, rel);
        chk("rs_read_byte", d, 64'(mdl_mem[mdl_pos]));
        chk("rs_released", rel, 1);
        mdl_pos = (mdl_pos + 1) % 8;
        i2c_stop();
        chk("rs_memory", memory, mdl_packed());
        chk("rs_mem_pos", mem_pos, 64'(mdl_pos));

        // Reset while the target is driving a 0 bit of a read byte.
        write_txn(8, 0, 0, 1'b0);
        i2c_start();
        write_byte(8'h32, ack);
        for (int i = 0; i < 3; i++) clock_bit(1'b1, s);
        chk("rr_bit4_driven", SDA === 1'b0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rr_sda_released", SDA === 1'b0, 0);
        chk("rr_req", req, 0);
        chk("rr_read", read, 0);
        chk("rr_busy", busy, 0);
        chk("rr_mem_pos", mem_pos, 0);
        chk("rr_memory", memory, 0);
        mdl_clear();
        scl_r = 1'b1;
        m_low = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        hp();
        write_txn(2, 0, 0, 1'b1);
        read_txn(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_slave_sync.md
I2C_SLAVE_SYNC -- requirements
Module: i2c_slave_sync

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'd25, 7-bit address this target responds to.
REQ-002 SHALL have parameter MIN_SCL_LOW, default 4, minimum SCL low/high phase in clk cycles that the design supports.
REQ-003 SHALL have port clk  input  1  system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port SCL  input  1  I2C clock (pulled up externally); observed only, never driven.
REQ-006 SHALL have port SDA  inout  1  I2C data; driven 1'b0 or released to 1'bz, never driven high.
REQ-007 SHALL have port req  output  1  high while this target is addressed and the transfer is in progress.
REQ-008 SHALL have port read  output  1  high when the current addressed transfer is a master read.
REQ-009 SHALL have port mem_pos  output  3  current memory pointer.
REQ-010 SHALL have port memory  output  8x8 (packed [7:0][7:0])  internal register file contents.
REQ-011 SHALL have port busy  output  1  high between a detected START and a detected STOP on the bus, whatever the address.

Function
REQ-012 SHALL pass SCL and SDA through 2-flop synchronizers; edges are detected on the synchronized values.
REQ-013 SHALL detect START when synchronized SDA falls while synchronized SCL is high, and STOP when synchronized SDA rises while synchronized SCL is high.
REQ-014 SHALL implement states IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
REQ-015 SHALL go from any state to ADDR on START, including a repeated START.
REQ-016 SHALL go from any state to IDLE on STOP, release SDA, and clear req and read.
REQ-017 ADDR: SHALL shift in 8 bits MSB first on SCL rising edges; bit 0 is R/W, with 1 = write and 0 = read.
REQ-018 On address match, SHALL enter ADDR_ACK, set req=1, and set read = ~R/W.
REQ-019 On address mismatch, SHALL enter WAIT_STOP and leave SDA released, which produces a NACK.
REQ-020 ADDR_ACK and WR_ACK: SHALL drive SDA low from the SCL falling edge after bit 8 until the SCL falling edge after the 9th clock.
REQ-021 WR_DATA: SHALL shift 8 bits; one clk after the 8th SCL rise it SHALL write memory[mem_pos] and set mem_pos = mem_pos+1 mod 8.
REQ-022 WR_DATA: a complete byte SHALL always be ACKed.
REQ-023 RD_DATA: SHALL load memory[mem_pos] on the SCL fall that ends the ACK slot, then present bits MSB first.
REQ-024 RD_DATA: each bit SHALL be updated within 3 clk of an SCL fall (SDA low for 0, released for 1).
REQ-025 RD_DATA: mem_pos SHALL increment mod 8 after the 8th bit's SCL fall.
REQ-026 RD_ACK: SHALL release SDA and sample SDA on the SCL rise; low (ACK) goes to RD_DATA, high (NACK) goes to WAIT_STOP.
REQ-027 mem_pos SHALL wrap from 7 to 0 silently, with no error and no NACK.
REQ-028 A partial byte interrupted by START or STOP SHALL be discarded: no memory write and no mem_pos change.
REQ-029 An SCL and SDA change in the same synchronized sample SHALL be classified as START or STOP when SCL is high, never as a data bit.
REQ-030 WAIT_STOP SHALL ignore all SCL activity until START or STOP.
REQ-031 SDA SHALL never change while synchronized SCL is high, except to release it on STOP or reset.

Reset
REQ-032 On rst_n low, SHALL asynchronously set state=IDLE, SDA released, req=0, read=0, busy=0, mem_pos=0, memory all 8'h00, and clear the shift registers and synchronizers (synchronizers to 1).
REQ-033 Reset mid-transfer SHALL release SDA in the same cycle rst_n falls, with no clk edge required; after reset the block SHALL ignore the bus until the next START.

Verification
REQ-034 Write: START, 0x33 (addr 25, W), bytes A1 B2 C3, STOP -> 4 ACKs, memory[0..2]=A1 B2 C3, mem_pos=3, req high only between address ACK and STOP.
REQ-035 Read: after REQ-034, START, 0x32 (addr 25, R), master ACK, ACK, NACK, STOP -> bytes read 00 00 00 from positions 3..5, mem_pos=6, read=1 during transfer, SDA released after the 3rd byte.
REQ-036 Mismatch: START, 0x35 (addr 26, W), 1 byte -> SDA high on both 9th clocks, memory and mem_pos unchanged, busy=1 until STOP.
REQ-037 Wrap: from mem_pos=0, write 10 bytes 01..0A -> memory[0]=09, memory[1]=0A, memory[2..7]=03..08, mem_pos=2.
REQ-038 Repeated START: write 2 bytes, repeated START, read 1 byte -> read byte=memory[2], the 3rd write-phase byte is not written, and there is no STOP in between.
REQ-039 Reset: rst_n low during bit 4 of a read byte -> SDA released immediately, all outputs at reset values, the next START with 0x33 is ACKed.
